// File: rtl/fetch_pc_ifid.sv
// -----------------------------------------------------------------------------
// fetch_pc_ifid
//
// Program counter register plus the IF/ID pipeline register of a classic
// five-stage in-order pipeline.
//
// Each unstalled cycle the next PC is chosen in this priority order:
//   1. branch target
//   2. jump target
//   3. PC+4
// The instruction read at the current PC is then latched into IF/ID.
//
// Build option:
//   JUMP_DELAY_SLOT_EN
//     Undefined (default): an unstalled redirect squashes the wrong-path
//       instruction being fetched. IF/ID is loaded with a NOP, PC_IF_ID=0 and
//       valid=0.
//     Defined: that instruction is kept as an architectural delay slot.
//
// Parameters:
//   RESET_PC          PC value loaded on reset.
//
// Ports:
//   clk               Single clock. All state updates on its rising edge.
//   reset             Synchronous, active-high reset.
//   stall             Hazard-unit hold. Freezes the PC and IF/ID.
//   jump_taken        J/JAL decoded in ID.
//   PC_JUMP_final     Jump target.
//   branch_taken      Resolved taken branch in ID.
//   PC_branch         Branch target.
//   imem_addr         Current PC to instruction memory (no added latency).
//   imem_rdata        Combinational instruction memory read data.
//   Instruction_code  IF/ID instruction register.
//   PC_IF_ID          IF/ID copy of PC+4 of the held instruction.
//   if_id_valid       IF/ID holds a real, unflushed instruction.
// -----------------------------------------------------------------------------
module fetch_pc_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_taken,
    input  logic [31:0] PC_JUMP_final,
    input  logic        branch_taken,
    input  logic [31:0] PC_branch,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_code,
    output logic [31:0] PC_IF_ID,
    output logic        if_id_valid
);

    localparam logic [31:0] Nop        = 32'h0000_0000;
    localparam logic [31:0] WordMask   = 32'hFFFF_FFFC;
    localparam logic [31:0] InstrBytes = 32'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_ifid_q, pc_ifid_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    // The adder wraps naturally at 32 bits, so 0xFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + InstrBytes;

    // Branch beats jump. Both collapse into one redirect, so only one flush
    // happens when both are asserted together.
    assign redirect = branch_taken | jump_taken;

    always_comb begin
        redirect_target = PC_JUMP_final;
        if (branch_taken) begin
            redirect_target = PC_branch;
        end
        // Targets are word-aligned before they reach the PC.
        redirect_target = redirect_target & WordMask;
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_ifid_d = pc_ifid_q;
        valid_d   = valid_q;

        if (!stall) begin
            if (redirect) begin
                pc_d = redirect_target;
`ifdef JUMP_DELAY_SLOT_EN
                // Delay slot: the instruction already fetched still retires.
                instr_d   = imem_rdata;
                pc_ifid_d = pc_plus4;
                valid_d   = 1'b1;
`else
                // Squash the wrong-path instruction.
                instr_d   = Nop;
                pc_ifid_d = 32'h0000_0000;
                valid_d   = 1'b0;
`endif
            end else begin
                pc_d      = pc_plus4;
                instr_d   = imem_rdata;
                pc_ifid_d = pc_plus4;
                valid_d   = 1'b1;
            end
        end
        // When stalled, redirect inputs are ignored. ID presents them again
        // on the first unstalled cycle.
    end

    // Reset has top priority. It discards any pending stall or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= Nop;
            pc_ifid_q <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_ifid_q <= pc_ifid_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_addr        = pc_q;
    assign Instruction_code = instr_q;
    assign PC_IF_ID         = pc_ifid_q;
    assign if_id_valid      = valid_q;

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Directed, table-driven bench for fetch_pc_ifid in its default build
// (no delay slot).
// Instruction memory is modelled as imem_rdata = addr ^ 32'hDEAD_BEEF.
module tb_fetch_pc_ifid;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_taken;
    logic [31:0] PC_JUMP_final;
    logic        branch_taken;
    logic [31:0] PC_branch;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_code;
    logic [31:0] PC_IF_ID;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_pc_ifid #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .jump_taken      (jump_taken),
        .PC_JUMP_final   (PC_JUMP_final),
        .branch_taken    (branch_taken),
        .PC_branch       (PC_branch),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .Instruction_code(Instruction_code),
        .PC_IF_ID        (PC_IF_ID),
        .if_id_valid     (if_id_valid)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic        jt;
        logic [31:0] pcb;
        logic [31:0] pcj;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pcifid;
        logic        e_valid;
    } vec_t;

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %08h expected %08h", name, row, act, exp);
        end
    endtask

    vec_t v[$];

    initial begin
        // Row inputs are applied before an edge.
        // Expected values are the outputs just after that edge.
        v.push_back('{1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0});            // 0 reset
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h4, mem(32'h0), 32'h4, 1});       // 1
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h8, mem(32'h4), 32'h8, 1});       // 2
        v.push_back('{0, 0, 0, 0, 0, 0, 32'hC, mem(32'h8), 32'hC, 1});       // 3
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h10, mem(32'hC), 32'h10, 1});     // 4
        v.push_back('{0, 0, 0, 1, 0, 32'h0040_0020,
                      32'h0040_0020, 32'h0, 32'h0, 0});                      // 5 jump at 0x10
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h0040_0024, mem(32'h0040_0020),
                      32'h0040_0024, 1});                                    // 6
        v.push_back('{0, 1, 0, 1, 0, 32'h300, 32'h0040_0024, mem(32'h0040_0020),
                      32'h0040_0024, 1});                                    // 7 stall+jump
        v.push_back('{0, 1, 0, 1, 0, 32'h300, 32'h0040_0024, mem(32'h0040_0020),
                      32'h0040_0024, 1});                                    // 8 stall+jump
        v.push_back('{0, 0, 0, 1, 0, 32'h300, 32'h300, 32'h0, 32'h0, 0});    // 9 jump taken
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h304, mem(32'h300), 32'h304, 1}); // 10
        v.push_back('{0, 0, 1, 1, 32'h100, 32'h200, 32'h100, 32'h0, 32'h0, 0}); // 11 both
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h104, mem(32'h100), 32'h104, 1}); // 12 one flush
        v.push_back('{0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0}); // 13
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1}); // 14 wrap
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h4, mem(32'h0), 32'h4, 1});       // 15
        v.push_back('{0, 0, 1, 0, 32'h0000_0123, 0, 32'h120, 32'h0, 32'h0, 0}); // 16 align
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h124, mem(32'h120), 32'h124, 1}); // 17
        v.push_back('{0, 1, 0, 1, 0, 32'h500, 32'h124, mem(32'h120), 32'h124, 1}); // 18
        v.push_back('{1, 1, 0, 1, 0, 32'h500, 32'h0, 32'h0, 32'h0, 0});      // 19 rst in stall
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h4, mem(32'h0), 32'h4, 1});       // 20
        v.push_back('{0, 0, 0, 1, 0, 32'h0000_0802, 32'h800, 32'h0, 32'h0, 0}); // 21 jump align
        v.push_back('{1, 0, 1, 0, 32'h900, 0, 32'h0, 32'h0, 32'h0, 0});      // 22 rst+redirect
        v.push_back('{0, 0, 0, 0, 0, 0, 32'h4, mem(32'h0), 32'h4, 1});       // 23

        for (int i = 0; i < v.size(); i++) begin
            reset         = v[i].rst;
            stall         = v[i].stl;
            branch_taken  = v[i].br;
            jump_taken    = v[i].jt;
            PC_branch     = v[i].pcb;
            PC_JUMP_final = v[i].pcj;
            @(posedge clk);
            #1;
            check("imem_addr", i, imem_addr, v[i].e_addr);
            check("Instruction_code", i, Instruction_code, v[i].e_instr);
            check("PC_IF_ID", i, PC_IF_ID, v[i].e_pcifid);
            check("if_id_valid", i, {31'b0, if_id_valid}, {31'b0, v[i].e_valid});
        end

        // Hand sequence: imem_addr follows the PC with no added latency.
        // It changes after the edge and stays stable mid-cycle.
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump_taken = 1'b0;
        @(posedge clk);
        #1;
        check("seq_addr_after_edge", 100, imem_addr, 32'h8);
        #3;
        check("seq_addr_mid_cycle", 101, imem_addr, 32'h8);
        check("seq_rdata_comb", 102, imem_rdata, mem(32'h8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
